cfu_req_arbiter: RTL and testbench
==================================

Name: cfu_req_arbiter

Overview:
- Shares one CFU request FIFO and one CFU response FIFO among NUM_REQ requesters, for example issue ports or harts.
- Tags each pushed request with the requester ID in the top ID_W bits of the FIFO word.
- Strips the tag from each response and routes the response back to the requester that issued it.
- Enforces a per-requester outstanding-transaction limit and flags responses that arrive with no matching outstanding request.

Parameters:
- NUM_REQ, 4, number of requesters; must be at least 2.
- DATA_WIDTH, 42, FIFO word width; equals the CFU FIFO width.
- ID_W, $clog2(NUM_REQ), width of the requester tag.
- PAYLOAD_W, DATA_WIDTH-ID_W, width of the untagged request/response payload.
- MAX_OUTSTANDING, 4, maximum number of in-flight requests per requester; must be at least 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_data  in  NUM_REQ x PAYLOAD_W  per-requester request payload
- req_ready  out  NUM_REQ  one-hot; the request is accepted this cycle
- resp_valid  out  NUM_REQ  one-hot; a response is presented to requester i
- resp_data  out  PAYLOAD_W  response payload, broadcast to all requesters
- resp_ready  in  NUM_REQ  per-requester response accept
- reqf_push  out  1  request FIFO push
- reqf_potential_push  out  1  request FIFO early push hint
- reqf_data_in  out  DATA_WIDTH  {id, payload}
- reqf_full  in  1  request FIFO full
- rspf_valid  in  1  response FIFO non-empty
- rspf_data_out  in  DATA_WIDTH  {id, payload}
- rspf_pop  out  1  response FIFO pop
- busy  out  1  any requester has an outstanding count above 0
- err_unexpected  out  1  sticky: a response arrived for a requester whose outstanding count was 0

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset (asynchronous assert): rr_ptr=0, all outstanding counters=0, err_unexpected=0.
  - All outputs are derived from these registers and from live inputs.
  - Under reset, req_ready, reqf_push, rspf_pop and busy are 0.
- Reset asserted mid-operation discards all tracking. Responses already in flight after reset are treated as unexpected.
- Eligibility: eligible[i] = req_valid[i] && (cnt[i] < MAX_OUTSTANDING).
- Arbitration (combinational, 0-cycle latency):
  - Round-robin search starting at rr_ptr; grant g is the first eligible index.
  - reqf_potential_push = |eligible, and is independent of reqf_full.
  - reqf_push = |eligible && !reqf_full.
  - reqf_data_in = {g[ID_W-1:0], req_data[g]}.
  - req_ready[g] = reqf_push; all other bits of req_ready are 0.
- rr_ptr update: on reqf_push, rr_ptr <= (g+1) mod NUM_REQ. With no push, rr_ptr holds.
- Full: while reqf_full=1 there is no grant and no pointer movement. Requesters hold req_valid and req_data stable; the bench checks this.
- Response routing (combinational):
  - rid = rspf_data_out[DATA_WIDTH-1 -: ID_W].
  - resp_data = rspf_data_out[PAYLOAD_W-1:0].
  - If rspf_valid && cnt[rid]>0: resp_valid[rid]=1 and rspf_pop = resp_ready[rid].
  - If rspf_valid && cnt[rid]==0: resp_valid=0, rspf_pop=1 (the response is dropped), and err_unexpected <= 1.
  - If rid >= NUM_REQ (non-power-of-two NUM_REQ): handled identically to the unexpected case.
- Counters, width $clog2(MAX_OUTSTANDING+1):
  - Increment cnt[g] on reqf_push.
  - Decrement cnt[rid] on a delivered pop.
  - Increment and decrement of the same index in the same cycle leaves the count unchanged.
  - A counter never wraps.
- busy = |cnt, driven from registers.
- err_unexpected stays set until reset.

Decomposition:
- Package cfu_arb_pkg holds:
  - the localparams ID_W and PAYLOAD_W;
  - typedef cfu_tagged_t, a packed struct {id, payload} of width DATA_WIDTH;
  - function rr_pick(mask, ptr), returning the grant index.
- Sub-module cfu_rr_arbiter: generic NUM_REQ round-robin picker that owns rr_ptr.
  - Inputs: eligible, advance.
  - Outputs: grant index, grant_valid.
- Counters and response routing remain in the top module.

Test Plan:
- NUM_REQ=4, reqf_full=0, all req_valid=1, cnt=0, for 4 cycles -> push IDs 0,1,2,3 in order; reqf_data_in[41:40] matches each ID; req_ready one-hot each cycle.
- Requester 2 only, 5 back-to-back requests, no responses -> 4 pushes; 5th held (req_ready[2]=0, reqf_potential_push=0); cnt[2]=4; busy=1.
- reqf_full=1 with req_valid=4'b1010 -> reqf_push=0 and reqf_potential_push=1. Release full -> push ID 1 first (rr_ptr=0), then ID 3.
- Response {2'd2, 40'hAB} with cnt[2]=1, resp_ready[2]=0 for 3 cycles, then 1 -> resp_valid=4'b0100 held with resp_data=40'hAB; pop occurs only on the 4th cycle; cnt[2]=0; busy=0.
- Response tagged ID 3 with cnt[3]=0 -> resp_valid=0, rspf_pop=1 on the same cycle, err_unexpected=1 next cycle and sticky.
- cnt[1]=2; simultaneous push from 1 and delivered response for 1 -> cnt[1] stays 2. Then assert rst_n=0 mid-stream -> cnt=0, err_unexpected=0, reqf_push=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cfu_arb_pkg.sv
// Shared sizing, tagged FIFO word layout and the round-robin pick helper
// for the CFU request/response arbiter.
package cfu_arb_pkg;

   localparam int NUM_REQ         = 4;
   localparam int DATA_WIDTH      = 42;
   localparam int ID_W            = $clog2(NUM_REQ);
   localparam int PAYLOAD_W       = DATA_WIDTH - ID_W;
   localparam int MAX_OUTSTANDING = 4;
   localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1);

   typedef struct packed {
      logic [ID_W-1:0]      id;
      logic [PAYLOAD_W-1:0] payload;
   } cfu_tagged_t;

   // First set bit of mask at or after ptr, wrapping modulo NUM_REQ.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                                input logic [ID_W-1:0]    ptr);
      logic [ID_W-1:0] pick;
      logic            found;
      int              idx;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (!found && mask[idx]) begin
            pick  = ID_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/cfu_req_arbiter_if.sv
// Requester-side handshakes plus the shared CFU request/response FIFO ports.
interface cfu_req_arbiter_if;
   import cfu_arb_pkg::*;

   logic [NUM_REQ-1:0]                req_valid;
   logic [NUM_REQ-1:0][PAYLOAD_W-1:0] req_data;
   logic [NUM_REQ-1:0]                req_ready;
   logic [NUM_REQ-1:0]                resp_valid;
   logic [PAYLOAD_W-1:0]              resp_data;
   logic [NUM_REQ-1:0]                resp_ready;
   logic                              reqf_push;
   logic                              reqf_potential_push;
   logic [DATA_WIDTH-1:0]             reqf_data_in;
   logic                              reqf_full;
   logic                              rspf_valid;
   logic [DATA_WIDTH-1:0]             rspf_data_out;
   logic                              rspf_pop;

   modport slave (
      input  req_valid, req_data, resp_ready, reqf_full, rspf_valid, rspf_data_out,
      output req_ready, resp_valid, resp_data, reqf_push, reqf_potential_push,
             reqf_data_in, rspf_pop
   );

   modport master (
      output req_valid, req_data, resp_ready, reqf_full, rspf_valid, rspf_data_out,
      input  req_ready, resp_valid, resp_data, reqf_push, reqf_potential_push,
             reqf_data_in, rspf_pop
   );

endinterface

// File: rtl/cfu_rr_arbiter.sv
// Round-robin picker owning rr_ptr; grant is combinational (0 cycles),
// pointer moves past the grant only when the caller reports advance.
module cfu_rr_arbiter
   import cfu_arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] eligible,
   input  logic               advance,
   output logic [ID_W-1:0]    grant,
   output logic               grant_valid
);

   logic [ID_W-1:0] rr_ptr;

   assign grant       = rr_pick(eligible, rr_ptr);
   assign grant_valid = |eligible;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (advance) begin
         rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
      end
   end

endmodule

// File: rtl/cfu_req_arbiter.sv
// Shares one CFU request/response FIFO pair among NUM_REQ requesters: 0-cycle grant,
// full FIFO or MAX_OUTSTANDING in flight stalls pushes, response pop waits on resp_ready.
module cfu_req_arbiter
   import cfu_arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   cfu_req_arbiter_if.slave   bus,
   output logic               busy,
   output logic               err_unexpected
);

   logic [CNT_W-1:0]   cnt [NUM_REQ];
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] inc_vec;
   logic [NUM_REQ-1:0] dec_vec;
   logic [ID_W-1:0]    grant;
   logic               grant_valid;
   logic               push;
   logic               hit;
   logic               deliver;
   cfu_tagged_t        req_word;
   cfu_tagged_t        rsp_word;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++)
         eligible[i] = bus.req_valid[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
   end

   cfu_rr_arbiter u_rr (
      .clk         (clk),
      .rst_n       (rst_n),
      .eligible    (eligible),
      .advance     (push),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // Live requests may be present during reset, so the push is gated by rst_n.
   assign push                    = grant_valid && !bus.reqf_full && rst_n;
   assign bus.reqf_push           = push;
   assign bus.reqf_potential_push = grant_valid;
   assign req_word.id             = grant;
   assign req_word.payload        = bus.req_data[grant];
   assign bus.reqf_data_in        = req_word;

   assign rsp_word      = bus.rspf_data_out;
   assign bus.resp_data = rsp_word.payload;

   always_comb begin
      bus.req_ready  = '0;
      bus.resp_valid = '0;
      bus.rspf_pop   = 1'b0;
      hit            = 1'b0;
      deliver        = 1'b0;
      inc_vec        = '0;
      dec_vec        = '0;
      if (push) begin
         bus.req_ready[grant] = 1'b1;
         inc_vec[grant]       = 1'b1;
      end
      // Out-of-range or untracked IDs are popped and dropped without presentation.
      if (bus.rspf_valid && rst_n) begin
         if (int'(rsp_word.id) < NUM_REQ && cnt[rsp_word.id] != '0) begin
            hit                         = 1'b1;
            bus.resp_valid[rsp_word.id] = 1'b1;
            deliver                     = bus.resp_ready[rsp_word.id];
            bus.rspf_pop                = deliver;
            dec_vec[rsp_word.id]        = deliver;
         end else begin
            bus.rspf_pop = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_unexpected <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++)
            cnt[i] <= '0;
      end else begin
         if (bus.rspf_valid && !hit)
            err_unexpected <= 1'b1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (inc_vec[i] && !dec_vec[i])
               cnt[i] <= cnt[i] + CNT_W'(1);
            else if (dec_vec[i] && !inc_vec[i])
               cnt[i] <= cnt[i] - CNT_W'(1);
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         busy = busy | (cnt[i] != '0);
   end

endmodule

// File: tb/tb_cfu_req_arbiter.sv
// Directed bench for cfu_req_arbiter: arbitration order, outstanding limit,
// full stall, response routing/backpressure, unexpected responses and async reset.
module tb_cfu_req_arbiter;
   import cfu_arb_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   logic err_unexpected;
   int   total = 0;
   int   bad   = 0;

   logic [PAYLOAD_W-1:0] pay [NUM_REQ];
   cfu_tagged_t          exp_word;

   cfu_req_arbiter_if bus ();

   cfu_req_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .busy           (busy),
      .err_unexpected (err_unexpected)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_rsp(input int id, input logic [PAYLOAD_W-1:0] p);
      bus.rspf_valid    = 1'b1;
      bus.rspf_data_out = {ID_W'(id), p};
   endtask

   initial begin
      for (int i = 0; i < NUM_REQ; i++) begin
         pay[i]          = 40'hC0_0000_0000 + PAYLOAD_W'(i * 'h111);
         bus.req_data[i] = pay[i];
      end
      // Reset with live traffic present: nothing may be accepted or popped.
      rst_n             = 1'b0;
      bus.req_valid     = 4'b1111;
      bus.resp_ready    = 4'b1111;
      bus.reqf_full     = 1'b0;
      bus.rspf_valid    = 1'b1;
      bus.rspf_data_out = '0;
      #2;
      chk("rst_push", bus.reqf_push, 0);
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_pop", bus.rspf_pop, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_unexpected, 0);
      bus.req_valid  = '0;
      bus.rspf_valid = 1'b0;
      bus.resp_ready = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // All requesters valid: grants walk 0,1,2,3.
      bus.req_valid = 4'b1111;
      for (int k = 0; k < NUM_REQ; k++) begin
         #1;
         exp_word.id      = ID_W'(k);
         exp_word.payload = pay[k];
         chk("rr_push", bus.reqf_push, 1);
         chk("rr_ready", bus.req_ready, 64'(1) << k);
         chk("rr_data", bus.reqf_data_in, exp_word);
         tick();
      end
      bus.req_valid = '0;
      #1;
      chk("rr_busy", busy, 1);

      // Return one response to each requester.
      bus.resp_ready = 4'b1111;
      for (int k = 0; k < NUM_REQ; k++) begin
         send_rsp(k, 40'h500 + PAYLOAD_W'(k));
         #1;
         chk("drain_vld", bus.resp_valid, 64'(1) << k);
         chk("drain_pop", bus.rspf_pop, 1);
         chk("drain_dat", bus.resp_data, 40'h500 + k);
         tick();
      end
      bus.rspf_valid = 1'b0;
      #1;
      chk("drain_busy", busy, 0);
      chk("drain_err", err_unexpected, 0);

      // Full FIFO: hint stays up, no push, pointer frozen.
      bus.reqf_full = 1'b1;
      bus.req_valid = 4'b1010;
      #1;
      chk("full_push", bus.reqf_push, 0);
      chk("full_hint", bus.reqf_potential_push, 1);
      chk("full_ready", bus.req_ready, 0);
      tick();
      chk("full_push2", bus.reqf_push, 0);
      tick();
      bus.reqf_full = 1'b0;
      #1;
      chk("unfull_ready1", bus.req_ready, 4'b0010);
      exp_word.id      = 2'd1;
      exp_word.payload = pay[1];
      chk("unfull_data1", bus.reqf_data_in, exp_word);
      tick();
      chk("unfull_ready3", bus.req_ready, 4'b1000);
      tick();
      bus.req_valid = '0;
      send_rsp(1, 40'h11);
      #1;
      chk("full_rsp1", bus.rspf_pop, 1);
      tick();
      send_rsp(3, 40'h33);
      #1;
      chk("full_rsp3", bus.resp_valid, 4'b1000);
      tick();
      bus.rspf_valid = 1'b0;

      // Requester 2 alone: four pushes, the fifth is held at the limit.
      bus.req_valid = 4'b0100;
      for (int k = 0; k < MAX_OUTSTANDING; k++) begin
         #1;
         chk("lim_ready", bus.req_ready, 4'b0100);
         tick();
      end
      #1;
      chk("lim_ready5", bus.req_ready, 0);
      chk("lim_push5", bus.reqf_push, 0);
      chk("lim_hint5", bus.reqf_potential_push, 0);
      chk("lim_busy", busy, 1);
      bus.req_valid  = '0;
      bus.resp_ready = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         send_rsp(2, 40'h2);
         #1;
         chk("lim_drain_pop", bus.rspf_pop, 1);
         tick();
      end

      // Response stalled by resp_ready; other requesters' ready must not pop it.
      send_rsp(2, 40'hAB);
      bus.resp_ready = 4'b1011;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_vld", bus.resp_valid, 4'b0100);
         chk("stall_dat", bus.resp_data, 40'hAB);
         chk("stall_pop", bus.rspf_pop, 0);
         tick();
      end
      bus.resp_ready = 4'b0100;
      #1;
      chk("stall_pop4", bus.rspf_pop, 1);
      tick();
      bus.rspf_valid = 1'b0;
      #1;
      chk("stall_busy", busy, 0);

      // Unexpected response for idle requester 3.
      bus.resp_ready = 4'b1111;
      send_rsp(3, 40'h55);
      #1;
      chk("unexp_vld", bus.resp_valid, 0);
      chk("unexp_pop", bus.rspf_pop, 1);
      chk("unexp_err0", err_unexpected, 0);
      tick();
      bus.rspf_valid = 1'b0;
      #1;
      chk("unexp_err1", err_unexpected, 1);
      tick();
      tick();
      chk("unexp_sticky", err_unexpected, 1);

      // Build cnt[1]=2, then push and deliver for 1 in the same cycle.
      bus.req_valid = 4'b0010;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("pre_push", bus.reqf_push, 1);
         tick();
      end
      send_rsp(1, 40'h66);
      bus.resp_ready = 4'b0010;
      #1;
      chk("same_push", bus.reqf_push, 1);
      chk("same_pop", bus.rspf_pop, 1);
      chk("same_vld", bus.resp_valid, 4'b0010);
      tick();
      bus.rspf_valid = 1'b0;
      // Count of 2 leaves exactly two more slots.
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("same_fill", bus.req_ready, 4'b0010);
         tick();
      end
      #1;
      chk("same_held", bus.reqf_push, 0);

      // Asynchronous reset mid-stream.
      bus.req_valid  = 4'b0011;
      bus.resp_ready = 4'b1111;
      send_rsp(1, 40'h77);
      #1;
      chk("mid_push", bus.reqf_push, 1);
      chk("mid_pop", bus.rspf_pop, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_push", bus.reqf_push, 0);
      chk("arst_ready", bus.req_ready, 0);
      chk("arst_pop", bus.rspf_pop, 0);
      chk("arst_busy", busy, 0);
      chk("arst_err", err_unexpected, 0);
      bus.req_valid  = '0;
      bus.rspf_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      // A response left over from before reset is now unexpected.
      send_rsp(1, 40'h88);
      #1;
      chk("stale_vld", bus.resp_valid, 0);
      chk("stale_pop", bus.rspf_pop, 1);
      tick();
      bus.rspf_valid = 1'b0;
      #1;
      chk("stale_err", err_unexpected, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
